// File: rtl/mdu_core_pkg.sv
// Shared MDU definitions: operation codes used by the E-stage controller and the
// MDU state encoding.
package mdu_core_pkg;

   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MFHI  = 4'd5,
      OP_MFLO  = 4'd6,
      OP_MTHI  = 4'd7,
      OP_MTLO  = 4'd8,
      OP_MADD  = 4'd9,
      OP_MADDU = 4'd10,
      OP_MSUB  = 4'd11,
      OP_MSUBU = 4'd12
   } mdu_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } mdu_state_e;

   // Operations that occupy the unit for a busy window before committing HI/LO.
   function automatic logic is_multi(input logic [3:0] op);
      case (op)
         OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
         OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_multi = 1'b1;
         default:                              is_multi = 1'b0;
      endcase
   endfunction

   function automatic logic is_div(input logic [3:0] op);
      case (op)
         OP_DIV, OP_DIVU: is_div = 1'b1;
         default:         is_div = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mdu_core_if.sv
// E-stage controller <-> MDU signal bundle: issue side driven by the controller,
// status and HI/LO read-back driven by the MDU.
interface mdu_core_if;
   logic        start;
   logic        cancel;
   logic [3:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic [31:0] rdata;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (output start, cancel, op, a, b,
                   input  busy, rdata, hi, lo);
   modport slave  (input  start, cancel, op, a, b,
                   output busy, rdata, hi, lo);
endinterface

// File: rtl/mdu_arith.sv
// Combinational MDU datapath: 64-bit {HI,LO} result for multiply, multiply-
// accumulate and divide operations, plus a divide-by-zero flag.
import mdu_core_pkg::*;

module mdu_arith (
   input  logic [3:0]  op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic [63:0] hilo_i,
   output logic [63:0] res_o,
   output logic        div_zero_o
);

   logic [63:0] sprod_s;
   logic [63:0] uprod_s;
   logic [31:0] abs_a_s;
   logic [31:0] abs_b_s;
   logic [31:0] udvs_s;
   logic [31:0] sdvs_s;
   logic [31:0] uq_s;
   logic [31:0] ur_s;
   logic [31:0] sq_mag_s;
   logic [31:0] sr_mag_s;
   logic [31:0] sq_s;
   logic [31:0] sr_s;

   // Low 64 bits of the product of sign-extended operands equal the signed product.
   assign sprod_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
   assign uprod_s = {32'd0, a_i} * {32'd0, b_i};

   // Signed divide runs on magnitudes; 0x80000000 / -1 falls out as 0x80000000, rem 0.
   assign abs_a_s  = a_i[31] ? (32'd0 - a_i) : a_i;
   assign abs_b_s  = b_i[31] ? (32'd0 - b_i) : b_i;
   assign udvs_s   = (b_i == 32'd0) ? 32'd1 : b_i;
   assign sdvs_s   = (b_i == 32'd0) ? 32'd1 : abs_b_s;
   assign uq_s     = a_i / udvs_s;
   assign ur_s     = a_i % udvs_s;
   assign sq_mag_s = abs_a_s / sdvs_s;
   assign sr_mag_s = abs_a_s % sdvs_s;
   assign sq_s     = (a_i[31] ^ b_i[31]) ? (32'd0 - sq_mag_s) : sq_mag_s;
   assign sr_s     = a_i[31] ? (32'd0 - sr_mag_s) : sr_mag_s;

   // Result select by operation.
   always_comb begin
      res_o      = hilo_i;
      div_zero_o = 1'b0;
      case (op_i)
         OP_MULT:  res_o = sprod_s;
         OP_MULTU: res_o = uprod_s;
         OP_MADD:  res_o = hilo_i + sprod_s;
         OP_MADDU: res_o = hilo_i + uprod_s;
         OP_MSUB:  res_o = hilo_i - sprod_s;
         OP_MSUBU: res_o = hilo_i - uprod_s;
         OP_DIV: begin
            res_o      = {sr_s, sq_s};
            div_zero_o = (b_i == 32'd0);
         end
         OP_DIVU: begin
            res_o      = {ur_s, uq_s};
            div_zero_o = (b_i == 32'd0);
         end
         default: res_o = hilo_i;
      endcase
   end

endmodule

// File: rtl/mdu_core.sv
// E-stage multiply/divide unit: owns HI/LO, captures multi-cycle results at issue
// and commits them after a fixed busy window.
import mdu_core_pkg::*;

module mdu_core #(
   parameter int unsigned MUL_CYCLES = 5,
   parameter int unsigned DIV_CYCLES = 10
) (
   input  logic      clk,
   input  logic      reset_n,
   mdu_core_if.slave bus
);

   localparam logic [3:0] MUL_N = 4'(MUL_CYCLES);
   localparam logic [3:0] DIV_N = 4'(DIV_CYCLES);

   mdu_state_e  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [63:0] pend_q, pend_d;
   logic        pend_dz_q, pend_dz_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [63:0] res_s;
   logic        div_zero_s;
   logic        accept_s;

   mdu_arith u_arith (
      .op_i       (bus.op),
      .a_i        (bus.a),
      .b_i        (bus.b),
      .hilo_i     ({hi_q, lo_q}),
      .res_o      (res_s),
      .div_zero_o (div_zero_s)
   );

   assign accept_s = bus.start & ~bus.cancel & (state_q == ST_IDLE);

   // State register, busy counter, pending result and HI/LO.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 4'd0;
         pend_q    <= 64'd0;
         pend_dz_q <= 1'b0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pend_q    <= pend_d;
         pend_dz_q <= pend_dz_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   // Next-state: issue, countdown and commit.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_d    = pend_q;
      pend_dz_d = pend_dz_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s && is_multi(bus.op)) begin
               state_d   = ST_BUSY;
               cnt_d     = is_div(bus.op) ? DIV_N : MUL_N;
               pend_d    = res_s;
               pend_dz_d = div_zero_s;
            end else if (accept_s) begin
               case (bus.op)
                  OP_MTHI: hi_d = bus.a;
                  OP_MTLO: lo_d = bus.a;
                  default: hi_d = hi_q;
               endcase
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (cnt_q == 4'd1) begin
               state_d = ST_IDLE;
               cnt_d   = 4'd0;
               if (!pend_dz_q) begin
                  hi_d = pend_q[63:32];
                  lo_d = pend_q[31:0];
               end else begin
                  hi_d = hi_q;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // HI/LO read-back for mfhi/mflo, combinational for the E-stage write mux.
   always_comb begin
      case (bus.op)
         OP_MFHI: bus.rdata = hi_q;
         OP_MFLO: bus.rdata = lo_q;
         default: bus.rdata = 32'd0;
      endcase
   end

   assign bus.busy = (state_q == ST_BUSY);
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_core.sv
// Self-checking bench for mdu_core: reference model feeds a scoreboard of
// expected {HI,LO} values, compared when each busy window closes.
import mdu_core_pkg::*;

module tb_mdu_core;

   localparam int MUL_N = 5;
   localparam int DIV_N = 10;

   logic clk;
   logic reset_n;
   int   n_checks;
   int   n_fail;
   int   n_proto;
   logic [63:0] sb_q[$];
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   mdu_core_if bus ();

   mdu_core #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (reset_n && bus.start && bus.busy) begin
         n_proto++;
         $display("protocol error: start issued while busy (op %0d)", bus.op);
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] hilo);
      longint      sp;
      logic [63:0] up;
      int          sa;
      int          sbv;
      sa  = $signed(a);
      sbv = $signed(b);
      sp  = longint'(sa) * longint'(sbv);
      up  = 64'(a) * 64'(b);
      case (op)
         OP_MULT:  return sp;
         OP_MULTU: return up;
         OP_MADD:  return hilo + sp;
         OP_MADDU: return hilo + up;
         OP_MSUB:  return hilo - sp;
         OP_MSUBU: return hilo - up;
         OP_DIV: begin
            if (b == 32'd0) return hilo;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            return {32'(sa % sbv), 32'(sa / sbv)};
         end
         OP_DIVU: begin
            if (b == 32'd0) return hilo;
            return {a % b, a / b};
         end
         default: return hilo;
      endcase
   endfunction

   // Called just after a negedge; returns just after the next negedge.
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic cancel);
      logic [63:0] exp;
      bus.op     = op;
      bus.a      = a;
      bus.b      = b;
      bus.cancel = cancel;
      bus.start  = 1'b1;
      if (!cancel && !bus.busy) begin
         if (is_multi(op)) begin
            exp = model(op, a, b, {m_hi, m_lo});
            sb_q.push_back(exp);
            m_hi = exp[63:32];
            m_lo = exp[31:0];
         end else if (op == OP_MTHI) begin
            m_hi = a;
         end else if (op == OP_MTLO) begin
            m_lo = a;
         end
      end
      @(posedge clk);
      #1;
      bus.start  = 1'b0;
      bus.cancel = 1'b0;
      bus.a      = $urandom;
      bus.b      = $urandom;
      @(negedge clk);
   endtask

   task automatic wait_done(input string tag, input int exp_n, input int pre);
      int cnt;
      logic [63:0] exp;
      cnt = pre;
      for (int g = 0; g < 64 && bus.busy === 1'b1; g++) begin
         cnt++;
         @(negedge clk);
      end
      check_eq({tag, "_busy_len"}, 64'(cnt), 64'(exp_n));
      if (sb_q.size() == 0) begin
         check_eq({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd1);
      end else begin
         exp = sb_q.pop_front();
         check_eq({tag, "_hilo"}, {bus.hi, bus.lo}, exp);
      end
   endtask

   initial begin
      logic [3:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      n_checks   = 0;
      n_fail     = 0;
      n_proto    = 0;
      m_hi       = 32'd0;
      m_lo       = 32'd0;
      reset_n    = 1'b0;
      bus.start  = 1'b0;
      bus.cancel = 1'b0;
      bus.op     = 4'd0;
      bus.a      = 32'd0;
      bus.b      = 32'd0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check_eq("reset_hilo", {bus.hi, bus.lo}, 64'd0);
      check_eq("reset_busy", 64'(bus.busy), 64'd0);

      issue(OP_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0);
      check_eq("mult_hilo_const", sb_q[0], 64'hFFFF_FFFF_FFFF_FFFE);
      wait_done("mult", MUL_N, 0);
      issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
      wait_done("multu", MUL_N, 0);
      check_eq("multu_const", {bus.hi, bus.lo}, 64'h0000_0001_FFFF_FFFE);

      issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
      wait_done("div", DIV_N, 0);
      check_eq("div_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      issue(OP_DIVU, 32'd7, 32'd2, 1'b0);
      wait_done("divu", DIV_N, 0);
      check_eq("divu_const", {bus.hi, bus.lo}, 64'h0000_0001_0000_0003);
      issue(OP_DIVU, 32'd5, 32'd0, 1'b0);
      wait_done("divu_zero", DIV_N, 0);
      check_eq("divu_zero_const", {bus.hi, bus.lo}, 64'h0000_0001_0000_0003);
      issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      wait_done("div_ovf", DIV_N, 0);
      check_eq("div_ovf_const", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);

      issue(OP_MTHI, 32'd0, 32'd0, 1'b0);
      issue(OP_MTLO, 32'd5, 32'd0, 1'b0);
      check_eq("mtlo_busy", 64'(bus.busy), 64'd0);
      issue(OP_MADD, 32'd3, 32'd4, 1'b0);
      wait_done("madd", MUL_N, 0);
      check_eq("madd_const", {bus.hi, bus.lo}, 64'h0000_0000_0000_0011);
      // Issued in the first idle cycle after the commit: back-to-back.
      issue(OP_MSUBU, 32'h20, 32'd1, 1'b0);
      wait_done("msubu", MUL_N, 0);
      check_eq("msubu_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFF1);

      issue(OP_MULT, 32'd9, 32'd9, 1'b1);
      check_eq("cancel_busy", 64'(bus.busy), 64'd0);
      check_eq("cancel_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});

      issue(OP_MULT, 32'd3, 32'd3, 1'b0);
      issue(OP_MULTU, 32'd7, 32'd7, 1'b0);
      wait_done("start_in_busy", MUL_N, 1);
      check_eq("start_in_busy_val", {bus.hi, bus.lo}, 64'd9);
      check_eq("proto_flagged", 64'(n_proto), 64'd1);

      issue(OP_MTLO, 32'h1234, 32'd0, 1'b0);
      bus.op = OP_MFLO;
      bus.start = 1'b1;
      #1;
      check_eq("mflo_rdata", 64'(bus.rdata), 64'h1234);
      bus.op = OP_MFHI;
      #1;
      check_eq("mfhi_rdata", 64'(bus.rdata), 64'(m_hi));
      bus.start = 1'b0;
      bus.op = 4'd13;
      #1;
      check_eq("other_rdata", 64'(bus.rdata), 64'd0);
      @(negedge clk);
      check_eq("mf_no_effect", {bus.hi, bus.lo}, {m_hi, m_lo});

      for (int i = 0; i < 10; i++) begin
         case ($urandom_range(0, 7))
            0: rop = OP_MULT;
            1: rop = OP_MULTU;
            2: rop = OP_MADD;
            3: rop = OP_MADDU;
            4: rop = OP_MSUB;
            5: rop = OP_MSUBU;
            6: rop = OP_DIV;
            default: rop = OP_DIVU;
         endcase
         ra = $urandom;
         rb = (i == 3) ? 32'd0 : $urandom;
         issue(rop, ra, rb, 1'b0);
         wait_done("rand", is_div(rop) ? DIV_N : MUL_N, 0);
      end

      issue(OP_DIV, 32'd100, 32'd7, 1'b0);
      repeat (3) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check_eq("rst_mid_busy", 64'(bus.busy), 64'd0);
      check_eq("rst_mid_hilo", {bus.hi, bus.lo}, 64'd0);
      sb_q.delete();
      m_hi = 32'd0;
      m_lo = 32'd0;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (DIV_N + 2) @(negedge clk);
      check_eq("rst_after_hilo", {bus.hi, bus.lo}, 64'd0);
      check_eq("rst_after_busy", 64'(bus.busy), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mdu_core.md
Name: mdu_core

Overview:
- Multiply/divide unit in the E stage; executes the operations the E-stage controller issues on enMDU/MDUOp.
- Owns the architectural HI/LO registers and models multi-cycle latency with a busy window, so hazard logic stalls MD-class instructions while an operation is in flight.
- Read data for mfhi/mflo is returned combinationally, to be selected onto the E-stage write-data mux.

Parameters:
- MUL_CYCLES, 5, busy cycles for mult/multu/madd/maddu/msub/msubu (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  enMDU from the E controller; operation valid this cycle.
- cancel  input  1  exception/interrupt in E; suppresses start this cycle.
- op  input  4  MDUOp code.
- a  input  32  forwarded rs operand.
- b  input  32  forwarded rt operand.
- busy  output  1  an operation is in flight.
- rdata  output  32  HI when op==MFHI, LO when op==MFLO, else 0; combinational from the current HI/LO.
- hi  output  32  current HI.
- lo  output  32  current LO.

Behaviour:
- Reset (async, reset_n low): HI=0, LO=0, busy=0, counter=0, state=IDLE. Reset mid-operation abandons the pending result; HI/LO stay 0.
- Accept condition: start & ~cancel & ~busy.
- start while busy is ignored. Hazard logic never issues it, and the bench flags it as a protocol error.
- MTHI/MTLO on accept: HI (or LO) <= a at that clock edge. No busy.
- MFHI/MFLO never set busy. start with these codes has no state effect.
- Multi-cycle ops (MULT, MULTU, MADD, MADDU, MSUB, MSUBU, DIV, DIVU) on accept:
  - Compute the 64-bit result from a, b and the current {HI,LO}, and hold it in pending registers. Later operand changes have no effect.
  - State goes to BUSY with counter = N (MUL_CYCLES or DIV_CYCLES).
- State machine:
  - IDLE --accept multi-cycle--> BUSY.
  - BUSY: counter decrements each cycle. In the cycle counter==1, the next edge commits pending to HI/LO and returns to IDLE.
  - busy is high for exactly N cycles after the accept edge. HI/LO show the new values in the first cycle busy is low.
  - Back-to-back accept is possible in that same cycle.
- Arithmetic:
  - MULT: signed 32x32 -> 64, {HI,LO}=product.
  - MULTU: unsigned 32x32 -> 64, {HI,LO}=product.
  - MADD/MSUB: {HI,LO} +/- signed product, modulo 2^64.
  - MADDU/MSUBU: same with the unsigned product.
  - DIV: signed; LO=quotient truncated toward zero, HI=remainder carrying the sign of the dividend.
  - DIVU: unsigned.
  - Divide by zero: busy window still runs; HI/LO unchanged at commit.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- cancel has no effect once an operation is in BUSY; in-flight operations always complete.
- MTHI/MTLO accepted in the commit cycle is impossible (busy is high in that cycle), so there is no write conflict.

Decomposition:
- Shared package/header holds the MDUOp codes, also consumed by the E controller: MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8, MADD=9, MADDU=10, MSUB=11, MSUBU=12.
- The same package holds the state encoding IDLE/BUSY.
- One sub-module, mdu_arith: combinational 64-bit result from op, a, b, {HI,LO}, plus a div-by-zero flag.
- mdu_core holds the FSM, counter, pending registers and HI/LO.

Test Plan:
- Reset then idle: hi=lo=0, busy=0. Assert reset_n low mid-DIV: busy drops immediately and HI/LO=0.
- MULT a=0xFFFFFFFF, b=2 -> busy for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 -> busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=7, b=2 -> LO=3, HI=1. DIVU b=0 -> HI/LO keep their previous values.
- MTHI 0, MTLO 5, then MADD a=3, b=4 -> HI=0, LO=0x11. Then MSUBU a=0x20, b=1 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- start with cancel=1 on MULT -> busy stays 0, HI/LO unchanged. start during busy -> ignored, protocol error flagged.
- MFLO after MTLO 0x1234 -> rdata=0x1234 in the same cycle. op=ADD-class code with start=0 -> rdata=0.
